// File: rtl/prog_ctrl_pkg.sv
// Shared types and constants for the UART program-download controller.
package prog_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic MEM_SEL_DMEM = 1'b1;
    localparam int   WORD_CNT_W   = 16;

    function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
        return (&v) ? v : v + WORD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/prog_mode_ctrl_if.sv
// UART download bus between uart_bmpg_0, the download controller and the memories.
// master: UART side driving beats and observing status; slave: the controller.
interface prog_mode_ctrl_if
    import prog_ctrl_pkg::*;
#(
    parameter int ADR_W = 15
) ();

    logic                  start_pg;
    logic                  upg_wen_i;
    logic [ADR_W-1:0]      upg_adr_i;
    logic [31:0]           upg_dat_i;
    logic                  upg_done_i;
    logic                  upg_rst;
    logic                  cpu_rst;
    logic                  imem_we;
    logic                  dmem_we;
    logic [ADR_W-2:0]      mem_adr;
    logic [31:0]           mem_dat;
    logic [WORD_CNT_W-1:0] word_cnt;
    logic                  busy;
    logic                  err_timeout;
    logic [31:0]           checksum;

    modport master (
        output start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        input  upg_rst, cpu_rst, imem_we, dmem_we, mem_adr, mem_dat,
               word_cnt, busy, err_timeout, checksum
    );

    modport slave (
        input  start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        output upg_rst, cpu_rst, imem_we, dmem_we, mem_adr, mem_dat,
               word_cnt, busy, err_timeout, checksum
    );

endinterface

// File: rtl/prog_watchdog.sv
// LOAD-state inactivity counter; o_timeout is combinational from the count register.
// Clear has priority over enable; the count parks at TIMEOUT_CYC instead of wrapping.
module prog_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 23_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [31:0] r_cnt;
    logic        w_timeout;

    assign w_timeout = (r_cnt >= 32'(TIMEOUT_CYC));
    assign o_timeout = w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_timeout) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/prog_mode_ctrl.sv
// UART program-download sequencer: UART/CPU reset control and imem/dmem write steering, 1-cycle write latency.
// No backpressure: every beat in LOAD is taken; optional running checksum under PROG_CHECKSUM_EN.
module prog_mode_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 23_000_000,
    parameter int unsigned DRAIN_CYC   = 16,
    parameter int unsigned ADR_W       = 15
) (
    input  logic              clk,
    input  logic              rst,
    prog_mode_ctrl_if.slave   bus
);

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_start_d;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic                  r_upg_rst;
    logic                  r_cpu_rst;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_imem_we;
    logic                  r_dmem_we;
    logic [ADR_W-2:0]      r_mem_adr;
    logic [31:0]           r_mem_dat;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic                  w_start_edge;
    logic                  w_accept;
    logic                  w_load_entry;
    logic                  w_timeout;
    logic                  w_sel_dmem;

    // start_pg edge register resets high so a level held across reset is not a request.
    assign w_start_edge = bus.start_pg & ~r_start_d;
    assign w_accept     = (r_state == LOAD) & bus.upg_wen_i;
    assign w_load_entry = (r_state != LOAD) & (w_next == LOAD);
    assign w_sel_dmem   = (bus.upg_adr_i[ADR_W-1] == MEM_SEL_DMEM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next = LOAD;
            LOAD:    if (bus.upg_done_i) w_next = DRAIN;
                     else if (w_timeout) w_next = ERR;
            DRAIN:   if (r_drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) w_next = IDLE;
            ERR:     if (w_start_edge) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_start_d   <= 1'b1;
            r_drain_cnt <= '0;
            r_upg_rst   <= 1'b1;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_d   <= bus.start_pg;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
            r_upg_rst   <= (w_next != LOAD);
            r_cpu_rst   <= (w_next != IDLE);
            r_busy      <= (w_next == LOAD) || (w_next == DRAIN);
            r_err       <= (w_next == ERR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_we  <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_dat  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_imem_we <= w_accept & ~w_sel_dmem;
            r_dmem_we <= w_accept &  w_sel_dmem;
            if (w_accept) begin
                r_mem_adr <= bus.upg_adr_i[ADR_W-2:0];
                r_mem_dat <= bus.upg_dat_i;
            end
            if (w_load_entry) begin
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_word_cnt <= sat_inc(r_word_cnt);
            end
        end
    end

    prog_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_load_entry | w_accept),
        .i_en      (r_state == LOAD),
        .o_timeout (w_timeout)
    );

`ifdef PROG_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_load_entry) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + bus.upg_dat_i;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 32'h0;
`endif

    assign bus.upg_rst     = r_upg_rst;
    assign bus.cpu_rst     = r_cpu_rst;
    assign bus.imem_we     = r_imem_we;
    assign bus.dmem_we     = r_dmem_we;
    assign bus.mem_adr     = r_mem_adr;
    assign bus.mem_dat     = r_mem_dat;
    assign bus.word_cnt    = r_word_cnt;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// Directed bench for prog_mode_ctrl: expected memory writes go to a queue checked by a negedge monitor.
module tb_prog_mode_ctrl;
    import prog_ctrl_pkg::*;

    localparam int ADR_W = 15;
    localparam int TO    = 100;
    localparam int DR    = 16;

    typedef struct packed {
        logic             sel;
        logic [ADR_W-2:0] adr;
        logic [31:0]      dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    prog_mode_ctrl_if #(.ADR_W(ADR_W)) bus ();

    prog_mode_ctrl #(
        .TIMEOUT_CYC (TO),
        .DRAIN_CYC   (DR),
        .ADR_W       (ADR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef PROG_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_pg = 1'b1;
        tick();
        bus.start_pg = 1'b0;
    endtask

    task automatic beat(input logic [ADR_W-1:0] adr, input logic [31:0] dat,
                        input logic exp_sel, input logic [ADR_W-2:0] exp_adr, input logic done);
        wr_t w;
        w.sel = exp_sel;
        w.adr = exp_adr;
        w.dat = dat;
        exp_q.push_back(w);
        bus.upg_wen_i  = 1'b1;
        bus.upg_adr_i  = adr;
        bus.upg_dat_i  = dat;
        bus.upg_done_i = done;
        tick();
        bus.upg_wen_i  = 1'b0;
        bus.upg_done_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_upg_rst"},  32'(bus.upg_rst), 32'd1);
        check({tag, "_cpu_rst"},  32'(bus.cpu_rst), 32'd1);
        check({tag, "_busy"},     32'(bus.busy), 32'd0);
        check({tag, "_err"},      32'(bus.err_timeout), 32'd0);
        check({tag, "_we"},       32'({bus.imem_we, bus.dmem_we}), 32'd0);
        check({tag, "_mem_adr"},  32'(bus.mem_adr), 32'd0);
        check({tag, "_mem_dat"},  bus.mem_dat, 32'd0);
        check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd0);
        check({tag, "_checksum"}, bus.checksum, 32'd0);
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.imem_we || bus.dmem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: imem_we=%0b dmem_we=%0b adr=0x%h dat=0x%08h expected none",
                             bus.imem_we, bus.dmem_we, bus.mem_adr, bus.mem_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("we_sel",  32'({bus.imem_we, bus.dmem_we}), 32'({~e.sel, e.sel}));
                    check("mem_adr", 32'(bus.mem_adr), 32'(e.adr));
                    check("mem_dat", bus.mem_dat, e.dat);
                end
            end
        end
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.start_pg   = 1'b0;
        bus.upg_wen_i  = 1'b0;
        bus.upg_adr_i  = '0;
        bus.upg_dat_i  = '0;
        bus.upg_done_i = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");

        rst = 1'b0;
        check("cpu_rst_before_edge", 32'(bus.cpu_rst), 32'd1);
        tick();
        check("idle_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check("idle_upg_rst", 32'(bus.upg_rst), 32'd1);
        check("idle_busy",    32'(bus.busy), 32'd0);

        // Write in IDLE is dropped.
        bus.upg_wen_i = 1'b1; bus.upg_adr_i = 15'h0007; bus.upg_dat_i = 32'h55;
        tick();
        bus.upg_wen_i = 1'b0;
        tick();
        check("idle_wen_cnt", 32'(bus.word_cnt), 32'd0);

        // Session 1: one imem and one dmem beat.
        pulse_start();
        check("load_busy",    32'(bus.busy), 32'd1);
        check("load_upg_rst", 32'(bus.upg_rst), 32'd0);
        check("load_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        beat(15'h0003, 32'hDEADBEEF, 1'b0, 14'h0003, 1'b0);
        beat(15'h4005, 32'h00000001, 1'b1, 14'h0005, 1'b0);
        tick();
        check("s1_word_cnt", 32'(bus.word_cnt), 32'd2);
        check("s1_checksum", bus.checksum, cs(32'hDEADBEF0));
        bus.upg_done_i = 1'b1;
        tick();
        bus.upg_done_i = 1'b0;
        check("drain_busy",    32'(bus.busy), 32'd1);
        check("drain_upg_rst", 32'(bus.upg_rst), 32'd1);
        bus.upg_wen_i = 1'b1; bus.upg_adr_i = 15'h4001; bus.upg_dat_i = 32'h77;
        tick();
        bus.upg_wen_i = 1'b0;
        check("drain_wen_cnt", 32'(bus.word_cnt), 32'd2);
        n = 0;
        while (bus.busy && n < 50) begin tick(); n++; end
        check("s1_released", 32'({bus.busy, bus.cpu_rst}), 32'd0);
        check("s1_hold_sum", bus.checksum, cs(32'hDEADBEF0));

        // Session 2: done coincides with the last beat; start_pg edge during DRAIN ignored.
        pulse_start();
        check("s2_cnt_clr", 32'(bus.word_cnt), 32'd0);
        check("s2_sum_clr", bus.checksum, 32'd0);
        beat(15'h0010, 32'h11111111, 1'b0, 14'h0010, 1'b0);
        beat(15'h4020, 32'h22222222, 1'b1, 14'h0020, 1'b1);
        n = 0;
        while (bus.busy && n < 40) begin
            bus.start_pg = (n >= 2 && n < 4);
            tick();
            n++;
        end
        bus.start_pg = 1'b0;
        check("drain_len",   32'(n), 32'(DR));
        check("s2_cpu_rst",  32'(bus.cpu_rst), 32'd0);
        check("s2_word_cnt", 32'(bus.word_cnt), 32'd2);
        check("s2_checksum", bus.checksum, cs(32'h33333333));
        repeat (3) tick();
        check("s2_stay_idle", 32'(bus.busy), 32'd0);

        // Session 3: watchdog expiry, then restart from ERR.
        pulse_start();
        n = 0;
        while (!bus.err_timeout && n < 400) begin tick(); n++; end
        check("to_err",       32'(bus.err_timeout), 32'd1);
        check("to_upg_rst",   32'(bus.upg_rst), 32'd1);
        check("to_cpu_rst",   32'(bus.cpu_rst), 32'd1);
        check("to_not_early", 32'(n >= TO), 32'd1);
        pulse_start();
        check("re_err",      32'(bus.err_timeout), 32'd0);
        check("re_busy",     32'(bus.busy), 32'd1);
        check("re_upg_rst",  32'(bus.upg_rst), 32'd0);
        check("re_word_cnt", 32'(bus.word_cnt), 32'd0);

        // Three beats, then asynchronous reset mid-LOAD with wen held high.
        beat(15'h0001, 32'h0000000A, 1'b0, 14'h0001, 1'b0);
        beat(15'h4002, 32'h0000000B, 1'b1, 14'h0002, 1'b0);
        beat(15'h7FFF, 32'hFFFFFFFF, 1'b1, 14'h3FFF, 1'b0);
        tick();
        check("s3_word_cnt", 32'(bus.word_cnt), 32'd3);
        check("s3_checksum", bus.checksum, cs(32'h00000014));
        bus.upg_wen_i = 1'b1; bus.upg_adr_i = 15'h0004; bus.upg_dat_i = 32'h99;
        #2 rst = 1'b1;
        #1 check_reset_values("async");
        repeat (3) tick();
        bus.upg_wen_i = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_cpu", 32'(bus.cpu_rst), 32'd0);
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
